// File: rtl/quad_encoder_pwm.sv
`default_nettype none
// ============================================================================
// quad_encoder_pwm - three encoder channels, each position sets its PWM duty
// Revision 1.0
// ============================================================================
module quad_encoder_pwm #(
  parameter int WIDTH        = 8,
  parameter int DEBOUNCE_LEN = 4
) (
  input  logic clock,
  input  logic resetb,
  input  logic enc0_a,
  input  logic enc0_b,
  input  logic enc1_a,
  input  logic enc1_b,
  input  logic enc2_a,
  input  logic enc2_b,
  output logic pwm0_out,
  output logic pwm1_out,
  output logic pwm2_out
);

  localparam int NCH = 3;
  localparam int NIN = 2 * NCH;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  // Bit 2c is channel c's A input, bit 2c+1 its B input.
  logic [NIN-1:0] enc_raw;
  logic [NIN-1:0] filt;
  logic [NCH-1:0] pwm;

  assign enc_raw = {enc2_b, enc2_a, enc1_b, enc1_a, enc0_b, enc0_a};

  // Shared free-running PWM timebase.
  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  generate
    for (genvar i = 0; i < NIN; i++) begin : g_in
      logic [1:0]              sync_q, sync_d;
      logic [DEBOUNCE_LEN-1:0] deb_q, deb_d;
      logic                    filt_q, filt_d;

      // Filter only moves once the whole sample window agrees.
      always_comb begin
        sync_d = {sync_q[0], enc_raw[i]};
        deb_d  = {deb_q[DEBOUNCE_LEN-2:0], sync_q[1]};
        filt_d = filt_q;
        if (&deb_q) begin
          filt_d = 1'b1;
        end else if (~|deb_q) begin
          filt_d = 1'b0;
        end
      end

      always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
          sync_q <= '0;
          deb_q  <= '0;
          filt_q <= 1'b0;
        end else begin
          sync_q <= sync_d;
          deb_q  <= deb_d;
          filt_q <= filt_d;
        end
      end

      assign filt[i] = filt_q;
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic [1:0]       s;
      logic [1:0]       s_idx, prev_idx, step;
      logic [1:0]       prev_q, prev_d;
      logic [WIDTH-1:0] pos_q, pos_d;
      logic [WIDTH-1:0] duty_q, duty_d;
      logic             pwm_q, pwm_d;

      assign s = {filt[2*c], filt[2*c+1]};

      // Map Gray state {a,b} 00,10,11,01 to phase 0..3; a phase step of
      // +1 is forward, +3 is reverse, +2 is an invalid double change.
      always_comb begin
        s_idx    = {s[0], s[1] ^ s[0]};
        prev_idx = {prev_q[0], prev_q[1] ^ prev_q[0]};
        step     = s_idx - prev_idx;
        prev_d   = s;
        pos_d    = pos_q;
        if (step == 2'd1) begin
          pos_d = pos_q + ONE;
        end else if (step == 2'd3) begin
          pos_d = pos_q - ONE;
        end
        duty_d = (cnt_q == CNT_MAX) ? pos_q : duty_q;
        pwm_d  = (cnt_q < duty_q);
      end

      always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
          prev_q <= '0;
          pos_q  <= '0;
          duty_q <= '0;
          pwm_q  <= 1'b0;
        end else begin
          prev_q <= prev_d;
          pos_q  <= pos_d;
          duty_q <= duty_d;
          pwm_q  <= pwm_d;
        end
      end

      assign pwm[c] = pwm_q;
    end
  endgenerate

  assign pwm0_out = pwm[0];
  assign pwm1_out = pwm[1];
  assign pwm2_out = pwm[2];

endmodule
`default_nettype wire

// File: tb/tb_quad_encoder_pwm.sv
`default_nettype none
// ============================================================================
// tb_quad_encoder_pwm - directed encoder stimulus, per-period PWM scoreboard
// Revision 1.0
// ============================================================================
module tb_quad_encoder_pwm;

  logic       clock;
  logic       resetb;
  logic [2:0] ea, eb;
  logic       pwm0_out, pwm1_out, pwm2_out;
  logic [2:0] pw;

  quad_encoder_pwm #(.WIDTH(8), .DEBOUNCE_LEN(4)) dut (
    .clock   (clock),
    .resetb  (resetb),
    .enc0_a  (ea[0]),
    .enc0_b  (eb[0]),
    .enc1_a  (ea[1]),
    .enc1_b  (eb[1]),
    .enc2_a  (ea[2]),
    .enc2_b  (eb[2]),
    .pwm0_out(pwm0_out),
    .pwm1_out(pwm1_out),
    .pwm2_out(pwm2_out)
  );

  assign pw = {pwm2_out, pwm1_out, pwm0_out};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    int win;
    int h[3];
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   n;
  int   st[3];

  // Clock edges since reset release; the PWM counter equals n mod 256.
  always @(posedge clock or negedge resetb) begin
    if (!resetb) n <= 0;
    else         n <= n + 1;
  end

  // Window w covers samples n = 256w+1 .. 256w+256. A duty of k must give
  // exactly k high samples at offsets 1..k, so the last high offset is k.
  initial begin : monitor
    int   hc[3];
    int   lasth[3];
    int   off, w;
    exp_t e;
    forever begin
      @(negedge clock);
      if (resetb && n > 0) begin
        off = (n - 1) % 256 + 1;
        if (off == 1) begin
          for (int c = 0; c < 3; c++) begin
            hc[c] = 0;
            lasth[c] = 0;
          end
        end
        for (int c = 0; c < 3; c++) begin
          if (pw[c]) begin
            hc[c]++;
            lasth[c] = off;
          end
        end
        if (off == 256) begin
          w = (n - 1) / 256;
          while (sbq.size() > 0 && sbq[0].win < w) begin
            checks++;
            errors++;
            $display("FAIL missed_window win=%0d got=none required=checked", sbq[0].win);
            void'(sbq.pop_front());
          end
          if (sbq.size() > 0 && sbq[0].win == w) begin
            e = sbq.pop_front();
            for (int c = 0; c < 3; c++) begin
              checks++;
              if (hc[c] != e.h[c] || lasth[c] != e.h[c]) begin
                errors++;
                $display("FAIL period_win%0d_pwm%0d high=%0d last=%0d required high=%0d last=%0d",
                         w, c, hc[c], lasth[c], e.h[c], e.h[c]);
              end
            end
          end
        end
      end
    end
  end

  function automatic int next_win();
    return n / 256 + 1;
  endfunction

  task automatic push(input int win, input int h0, input int h1, input int h2);
    exp_t e;
    e.win  = win;
    e.h[0] = h0;
    e.h[1] = h1;
    e.h[2] = h2;
    sbq.push_back(e);
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%b required=%b", name, act, req);
    end
  endtask

  task automatic wait_empty();
    int k;
    k = 0;
    while (sbq.size() > 0 && k < 1500) begin
      @(negedge clock);
      k++;
    end
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_timeout got=%0d pending required=0", sbq.size());
      sbq.delete();
    end
  endtask

  // Forward phase order for {a,b}: 00, 10, 11, 01.
  task automatic drive(input int ch, input int dir, input int edges);
    for (int k = 0; k < edges; k++) begin
      @(negedge clock);
      st[ch] = (st[ch] + dir + 4) % 4;
      case (st[ch])
        0: begin ea[ch] = 1'b0; eb[ch] = 1'b0; end
        1: begin ea[ch] = 1'b1; eb[ch] = 1'b0; end
        2: begin ea[ch] = 1'b1; eb[ch] = 1'b1; end
        default: begin ea[ch] = 1'b0; eb[ch] = 1'b1; end
      endcase
      repeat (11) @(negedge clock);
    end
  endtask

  task automatic wait_offset(input int target);
    int k;
    k = 0;
    @(negedge clock);
    while (!(n > 0 && (n - 1) % 256 + 1 == target) && k < 600) begin
      @(negedge clock);
      k++;
    end
    if (k >= 600) begin
      checks++;
      errors++;
      $display("FAIL offset_timeout got=%0d required=%0d", (n - 1) % 256 + 1, target);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "simulation timeout");
  end

  initial begin : stim
    int w;
    resetb = 1'b0;
    ea = '0;
    eb = '0;
    for (int c = 0; c < 3; c++) st[c] = 0;

    // Reset held with encoders toggling.
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      ea = 3'($urandom);
      eb = 3'($urandom);
    end
    #1;
    check_bit("reset_pwm0", pwm0_out, 1'b0);
    check_bit("reset_pwm1", pwm1_out, 1'b0);
    check_bit("reset_pwm2", pwm2_out, 1'b0);
    @(negedge clock);
    ea = '0;
    eb = '0;
    @(negedge clock);
    resetb = 1'b1;
    push(0, 0, 0, 0);
    push(1, 0, 0, 0);
    wait_empty();

    // Forward 20 edges on channel 0.
    drive(0, 1, 20);
    push(next_win(), 20, 0, 0);
    wait_empty();

    // Reverse through zero, then forward through 255.
    drive(1, -1, 4);
    push(next_win(), 20, 252, 0);
    wait_empty();
    drive(1, 1, 8);
    push(next_win(), 20, 4, 0);
    wait_empty();

    // Short glitches and an invalid double transition on channel 2.
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      ea[2] = 1'b1;
      repeat (2) @(negedge clock);
      ea[2] = 1'b0;
      repeat (3) @(negedge clock);
    end
    @(negedge clock);
    ea[2] = 1'b1;
    eb[2] = 1'b1;
    repeat (20) @(negedge clock);
    ea[2] = 1'b0;
    eb[2] = 1'b0;
    repeat (20) @(negedge clock);
    push(next_win(), 20, 4, 0);
    wait_empty();

    // Count drops while channel 0 is mid high phase; this period keeps 20.
    wait_offset(1);
    w = (n - 1) / 256;
    push(w, 20, 4, 0);
    drive(0, -1, 4);
    push(next_win(), 16, 4, 0);
    wait_empty();

    // Asynchronous reset while pwm0 is high.
    wait_offset(5);
    check_bit("pre_reset_pwm0", pwm0_out, 1'b1);
    check_bit("pre_reset_pwm1", pwm1_out, 1'b0);
    #2;
    resetb = 1'b0;
    #1;
    check_bit("async_reset_pwm0", pwm0_out, 1'b0);
    check_bit("async_reset_pwm1", pwm1_out, 1'b0);
    check_bit("async_reset_pwm2", pwm2_out, 1'b0);
    repeat (10) @(negedge clock);
    resetb = 1'b1;
    push(0, 0, 0, 0);
    wait_empty();

    // All channels concurrently.
    fork
      drive(0, 1, 10);
      drive(1, 1, 30);
      drive(2, 1, 100);
    join
    push(next_win(), 10, 30, 100);
    wait_empty();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/quad_encoder_pwm.md
Name: quad_encoder_pwm

Overview:
- User-project block for the Caravel harness, reached through mprj_io.
- Contains three identical channels. Each channel has a quadrature-encoder input pair (pins mprj_io[8..13]) and a PWM output (pins mprj_io[14..16]).
- Each channel's encoder position directly sets the duty cycle of its own PWM output.

Parameters:
- WIDTH, 8: bit width of the position counters, the PWM counter and the duty registers.
- DEBOUNCE_LEN, 4: number of consecutive equal synchronized samples required before a filtered encoder input changes.

Ports:
- clock  input  1  system clock; all state is on its rising edge.
- resetb  input  1  asynchronous, active-low reset.
- enc0_a, enc0_b  input  1 each  channel 0 quadrature pair (asynchronous).
- enc1_a, enc1_b  input  1 each  channel 1 quadrature pair.
- enc2_a, enc2_b  input  1 each  channel 2 quadrature pair.
- pwm0_out, pwm1_out, pwm2_out  output  1 each  registered PWM outputs for channels 0..2.

Behaviour:
- Reset (resetb=0, asynchronous) clears the following to 0:
  - synchronizers, debounce shift registers, filtered a/b and previous-state registers;
  - position counters, duty registers, PWM counter;
  - all pwm outputs.
  State holds while resetb=0. Operation resumes on the first clock edge after release.
- Synchronizer: each enc input passes through 2 flip-flops.
- Debounce, per input:
  - A DEBOUNCE_LEN-deep shift register samples the synchronized value every clock.
  - The filtered value takes a new value only when all DEBOUNCE_LEN samples equal it and it differs from the current filtered value.
  - Glitches shorter than DEBOUNCE_LEN clocks are never seen.
- Decoder, per channel:
  - State s={a,b} (filtered); prev holds s from the previous cycle.
  - Increment by 1 on transitions 00→10, 10→11, 11→01, 01→00 (a leads b).
  - Decrement by 1 on the reverse transitions 00→01, 01→11, 11→10, 10→00.
  - No change when s==prev. Invalid transitions (both bits changed: 00↔11, 01↔10) are ignored.
  - The count updates on the clock after the filtered change.
  - Counter is WIDTH-bit unsigned and wraps modulo 2^WIDTH: 255+1→0, 0−1→255.
- Latency: a clean pin edge held stable is reflected in the count between DEBOUNCE_LEN+2 and DEBOUNCE_LEN+4 clocks later.
- PWM:
  - One shared WIDTH-bit free-running counter increments every clock and wraps 2^WIDTH−1→0.
  - When the counter equals 2^WIDTH−1, each channel's duty register loads its position count, so duty changes only at period boundaries (glitch-free).
  - pwmN_out is registered: it is 1 in the cycle after the counter value is less than dutyN.
  - duty=0 → output constantly 0. duty=k → exactly k high cycles per 2^WIDTH-cycle period, contiguous, starting at counter 0 (plus 1-cycle register delay).
  - Maximum high time is 255/256, i.e. never constantly 1 at WIDTH=8.
- Simultaneous events:
  - A count change in the same cycle as the duty load: the duty register takes the pre-change count; the new value applies in the next period.
  - Channels are fully independent.
- Reset asserted mid-period forces outputs low immediately (asynchronous). After release the first period starts from counter 0 with duty 0.

Test Plan:
- Reset check: hold resetb=0 for 10 clocks with encoders toggling → all pwm outputs 0. Release, no encoder activity for 512 clocks → outputs stay 0.
- Forward count: drive enc0 through 00→10→11→01→00 ×5 (20 edges, each held ≥10 clocks). After the next period boundary, pwm0 is high exactly 20 of every 256 clocks. pwm1 and pwm2 stay 0.
- Reverse wrap: from reset, drive enc1 in reverse for 4 edges → count 252, pwm1 high 252/256 clocks. Then 8 forward edges → count 4, pwm1 high 4/256.
- Debounce: pulse enc2_a high for 2 clocks (less than DEBOUNCE_LEN), repeated 50 times → count stays 0 and pwm2 stays 0. An invalid 00→11 jump held stable → no count change.
- Period-boundary duty update: change enc0 count mid-period → the current period's high time is unchanged; the new duty appears starting at the following counter 0.
- Independence/simultaneity: drive all three channels forward 10, 30 and 100 edges concurrently → pwm0, pwm1, pwm2 high 10, 30 and 100 clocks per 256-clock period respectively.
